alu_protocol_monitor: RTL and testbench

Synthesisable, parametrised successor to the ALU assertion checker. It is a passive monitor that sits beside the ALU DUT on the same input and output nets. It tracks split operand arrival (INP_VALID 01/10) across a bounded wait window. It aligns result checks to the DUT pipeline latency and reports violations through a pulse, a sticky mask and saturating per-class counters that the bench or the top level can read.

---
 rtl/alu_mon_pkg.sv | 71 +++++++
 rtl/alu_mon_lat_pipe.sv | 27 ++
 rtl/alu_protocol_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_alu_protocol_monitor.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mon_pkg.sv
// Shared types, class indices and operand-requirement decode
// for the ALU protocol monitor.
package alu_mon_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } mon_state_t;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_A,
        REQ_B,
        REQ_BOTH,
        REQ_ILLEGAL
    } req_t;

    localparam int C_ILLEGAL_CMD     = 0;
    localparam int C_VALID_MISMATCH  = 1;
    localparam int C_OPERAND_TIMEOUT = 2;
    localparam int C_CMD_CHANGED     = 3;
    localparam int C_CE_HOLD         = 4;
    localparam int C_LOGIC_FLAG      = 5;
    localparam int C_CMP_MISMATCH    = 6;
    localparam int C_ROT_ERR         = 7;
    localparam int NUM_CLASSES       = 8;

    // Legal commands never exceed 13, so 8 bits in the pipe is lossless.
    localparam int PIPE_CMD_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  mode;
        logic [PIPE_CMD_W-1:0] cmd;
        logic                  exp_g;
        logic                  exp_l;
        logic                  exp_e;
        logic                  rot_bad;
    } exp_t;

    function automatic req_t req_of(input logic mode, input logic [31:0] cmd);
        req_t r;
        r = REQ_ILLEGAL;
        if (mode) begin
            unique case (1'b1)
                (cmd inside {4, 5}):          r = REQ_A;
                (cmd inside {6, 7}):          r = REQ_B;
                (cmd inside {[0:3], [8:10]}): r = REQ_BOTH;
                default:                      r = REQ_ILLEGAL;
            endcase
        end else begin
            unique case (1'b1)
                (cmd inside {6, 8, 9}):          r = REQ_A;
                (cmd inside {7, 10, 11}):        r = REQ_B;
                (cmd inside {[0:5], 12, 13}):    r = REQ_BOTH;
                default:                         r = REQ_ILLEGAL;
            endcase
        end
        return r;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [NUM_CLASSES-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_mon_lat_pipe.sv
// Fixed-depth shift pipe carrying the expected-result record
// from operand completion to the cycle the DUT presents its result.
module alu_mon_lat_pipe
    import alu_mon_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  exp_t push,
    output exp_t pop
);

    exp_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign pop = stage[DEPTH-1];

endmodule

// File: rtl/alu_protocol_monitor.sv
// Passive ALU protocol monitor: split-operand tracking, latency-aligned
// result checks, registered violation reporting and saturating counters.
module alu_protocol_monitor
    import alu_mon_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int WAIT_CYCLES = 16,
    parameter int DUT_LAT     = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic                 CIN,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic [WIDTH:0]       RES,
    input  logic                 ERR,
    input  logic                 OFLOW,
    input  logic                 COUT,
    input  logic                 G,
    input  logic                 L,
    input  logic                 E,
    output logic                 viol_valid,
    output logic [2:0]           viol_code,
    output logic [7:0]           viol_vec,
    output logic [7:0]           viol_mask,
    input  logic [2:0]           cnt_sel,
    output logic [CNT_WIDTH-1:0] cnt_value,
    output logic                 busy
);

    localparam int WCW      = $clog2(WAIT_CYCLES + 1);
    localparam int ROT_BITS = $clog2(WIDTH);

    mon_state_t           state, nxt_state;
    logic [WCW-1:0]       wcnt, nxt_wcnt;
    logic [1:0]           rcv, nxt_rcv, rcv_or;
    logic [CMD_WIDTH-1:0] lat_cmd, nxt_cmd, iss_cmd;
    logic                 lat_mode, nxt_mode, iss_mode;
    logic [WIDTH-1:0]     lat_a, lat_b, nxt_a, nxt_b, iss_a, iss_b;
    logic                 issue;
    req_t                 req;
    logic                 hold_q;
    logic [WIDTH:0]       res_q;
    logic [NUM_CLASSES-1:0] det;
    logic [CNT_WIDTH-1:0] cnt [NUM_CLASSES];
    exp_t                 push, pop;
    logic                 unused_cin;

    assign unused_cin = CIN;
    assign req        = req_of(MODE, 32'(CMD));
    assign rcv_or     = rcv | INP_VALID;

    always_comb begin
        det       = '0;
        issue     = 1'b0;
        iss_a     = OPA;
        iss_b     = OPB;
        iss_mode  = MODE;
        iss_cmd   = CMD;
        nxt_state = state;
        nxt_wcnt  = wcnt;
        nxt_rcv   = rcv;
        nxt_cmd   = lat_cmd;
        nxt_mode  = lat_mode;
        nxt_a     = lat_a;
        nxt_b     = lat_b;
        if (CE) begin
            unique case (state)
                IDLE: begin
                    if (INP_VALID != 2'b00) begin
                        unique case (req)
                            REQ_ILLEGAL: det[C_ILLEGAL_CMD] = 1'b1;
                            REQ_A: begin
                                if (INP_VALID == 2'b01) issue = 1'b1;
                                else det[C_VALID_MISMATCH] = 1'b1;
                            end
                            REQ_B: begin
                                if (INP_VALID == 2'b10) issue = 1'b1;
                                else det[C_VALID_MISMATCH] = 1'b1;
                            end
                            REQ_BOTH: begin
                                if (INP_VALID == 2'b11) begin
                                    issue = 1'b1;
                                end else begin
                                    nxt_state = WAIT;
                                    nxt_rcv   = INP_VALID;
                                    nxt_wcnt  = WCW'(1);
                                    nxt_cmd   = CMD;
                                    nxt_mode  = MODE;
                                    nxt_a     = OPA;
                                    nxt_b     = OPB;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT: begin
                    if (CMD != lat_cmd || MODE != lat_mode) begin
                        det[C_CMD_CHANGED] = 1'b1;
                        nxt_state          = IDLE;
                    end else begin
                        nxt_rcv = rcv_or;
                        if (INP_VALID[0] && !rcv[0]) nxt_a = OPA;
                        if (INP_VALID[1] && !rcv[1]) nxt_b = OPB;
                        if (rcv_or == 2'b11) begin
                            issue     = 1'b1;
                            iss_a     = nxt_a;
                            iss_b     = nxt_b;
                            iss_mode  = lat_mode;
                            iss_cmd   = lat_cmd;
                            nxt_state = IDLE;
                        end else if (wcnt == WCW'(WAIT_CYCLES)) begin
                            det[C_OPERAND_TIMEOUT] = 1'b1;
                            nxt_state              = IDLE;
                        end else begin
                            nxt_wcnt = wcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (pop.valid) begin
                if (!pop.mode) begin
                    if (OFLOW || COUT) det[C_LOGIC_FLAG] = 1'b1;
                    if ((pop.cmd == 8'd12 || pop.cmd == 8'd13) && pop.rot_bad && !ERR)
                        det[C_ROT_ERR] = 1'b1;
                end else if (pop.cmd == 8'd8 && {G, L, E} != {pop.exp_g, pop.exp_l, pop.exp_e}) begin
                    det[C_CMP_MISMATCH] = 1'b1;
                end
            end
        end
        // Hold check watches the DUT result even while CE is low.
        if (hold_q && RES != res_q) det[C_CE_HOLD] = 1'b1;
    end

    always_comb begin
        push         = '0;
        push.valid   = issue;
        push.mode    = iss_mode;
        push.cmd     = PIPE_CMD_W'(iss_cmd);
        push.exp_g   = iss_a > iss_b;
        push.exp_l   = iss_a < iss_b;
        push.exp_e   = iss_a == iss_b;
        push.rot_bad = (iss_b >> ROT_BITS) != '0;
    end

    alu_mon_lat_pipe #(
        .DEPTH (DUT_LAT)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            rcv        <= '0;
            lat_cmd    <= '0;
            lat_mode   <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            hold_q     <= 1'b0;
            res_q      <= '0;
            viol_valid <= 1'b0;
            viol_code  <= '0;
            viol_vec   <= '0;
            viol_mask  <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        end else begin
            state      <= nxt_state;
            wcnt       <= nxt_wcnt;
            rcv        <= nxt_rcv;
            lat_cmd    <= nxt_cmd;
            lat_mode   <= nxt_mode;
            lat_a      <= nxt_a;
            lat_b      <= nxt_b;
            hold_q     <= !CE;
            res_q      <= RES;
            viol_valid <= |det;
            viol_code  <= lowest_idx(det);
            viol_vec   <= det;
            viol_mask  <= clr ? det : (viol_mask | det);
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (clr) cnt[i] <= CNT_WIDTH'(det[i]);
                else if (det[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign cnt_value = cnt[cnt_sel];
    assign busy      = (state == WAIT);

endmodule

// File: tb/tb_alu_protocol_monitor.sv
// Directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference model.
module tb_alu_protocol_monitor;

    localparam int WIDTH       = 8;
    localparam int CMD_WIDTH   = 4;
    localparam int WAIT_CYCLES = 16;
    localparam int DUT_LAT     = 2;
    localparam int CNT_WIDTH   = 16;

    logic                 clk = 1'b0;
    logic                 rst, clr, ce, mode, cin;
    logic [CMD_WIDTH-1:0] cmd;
    logic [1:0]           inp_valid;
    logic [WIDTH-1:0]     opa, opb;
    logic [WIDTH:0]       res;
    logic                 err, oflow, cout, g, l, e;
    logic                 viol_valid, busy;
    logic [2:0]           viol_code, cnt_sel;
    logic [7:0]           viol_vec, viol_mask;
    logic [CNT_WIDTH-1:0] cnt_value;

    alu_protocol_monitor #(
        .WIDTH       (WIDTH),
        .CMD_WIDTH   (CMD_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .DUT_LAT     (DUT_LAT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .CE         (ce),
        .MODE       (mode),
        .CIN        (cin),
        .CMD        (cmd),
        .INP_VALID  (inp_valid),
        .OPA        (opa),
        .OPB        (opb),
        .RES        (res),
        .ERR        (err),
        .OFLOW      (oflow),
        .COUT       (cout),
        .G          (g),
        .L          (l),
        .E          (e),
        .viol_valid (viol_valid),
        .viol_code  (viol_code),
        .viol_vec   (viol_vec),
        .viol_mask  (viol_mask),
        .cnt_sel    (cnt_sel),
        .cnt_value  (cnt_value),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending-operand bookkeeping plus a queue of
    // expected results stamped with the cycle they must appear.
    typedef struct {
        int exit_cyc;
        bit md;
        int c;
        bit xg, xl, xe, rot;
    } rec_t;

    rec_t     q[$];
    bit       m_pend;
    int       m_rcv, m_wcnt, m_cmd, m_a, m_b, m_res;
    bit       m_mode, m_hold;
    int       m_cnt[8];
    bit [7:0] m_mask, m_vec;
    int       cyc = 0;

    function automatic int need(bit md, int c);
        if (md) begin
            if (c == 4 || c == 5) return 1;
            if (c == 6 || c == 7) return 2;
            if (c <= 10) return 3;
            return -1;
        end
        if (c == 6 || c == 8 || c == 9) return 1;
        if (c == 7 || c == 10 || c == 11) return 2;
        if (c <= 5 || c == 12 || c == 13) return 3;
        return -1;
    endfunction

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic issue(bit md, int c, int a, int b);
        q.push_back('{cyc + DUT_LAT, md, c, a > b, a < b, a == b, (b / WIDTH) != 0});
    endtask

    task automatic model_step();
        bit [7:0] d = '0;
        int rq;
        rec_t r;
        if (rst) begin
            m_pend = 0;
            q.delete();
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_mask = '0;
            m_vec  = '0;
            m_hold = 0;
            m_res  = 0;
            return;
        end
        if (q.size() > 0 && q[0].exit_cyc == cyc) begin
            r = q.pop_front();
            if (ce) begin
                if (!r.md) begin
                    if (oflow || cout) d[5] = 1;
                    if ((r.c == 12 || r.c == 13) && r.rot && !err) d[7] = 1;
                end else if (r.c == 8 && {g, l, e} != {r.xg, r.xl, r.xe}) begin
                    d[6] = 1;
                end
            end
        end
        if (ce) begin
            rq = need(mode, int'(cmd));
            if (!m_pend) begin
                if (inp_valid != 0) begin
                    if (rq < 0) d[0] = 1;
                    else if (rq != 3) begin
                        if (int'(inp_valid) == rq) issue(mode, int'(cmd), int'(opa), int'(opb));
                        else d[1] = 1;
                    end else if (inp_valid == 3) issue(mode, int'(cmd), int'(opa), int'(opb));
                    else begin
                        m_pend = 1;
                        m_rcv  = int'(inp_valid);
                        m_wcnt = 1;
                        m_cmd  = int'(cmd);
                        m_mode = mode;
                        m_a    = int'(opa);
                        m_b    = int'(opb);
                    end
                end
            end else if (int'(cmd) != m_cmd || mode != m_mode) begin
                d[3]   = 1;
                m_pend = 0;
            end else begin
                if (inp_valid[0] && !m_rcv[0]) m_a = int'(opa);
                if (inp_valid[1] && !m_rcv[1]) m_b = int'(opb);
                m_rcv = m_rcv | int'(inp_valid);
                if (m_rcv == 3) begin
                    issue(m_mode, m_cmd, m_a, m_b);
                    m_pend = 0;
                end else if (m_wcnt == WAIT_CYCLES) begin
                    d[2]   = 1;
                    m_pend = 0;
                end else m_wcnt++;
            end
        end
        if (m_hold && int'(res) != m_res) d[4] = 1;
        m_hold = !ce;
        m_res  = int'(res);
        for (int i = 0; i < 8; i++) begin
            if (clr) m_cnt[i] = d[i];
            else if (d[i] && m_cnt[i] < 65535) m_cnt[i]++;
        end
        m_mask = clr ? d : (m_mask | d);
        m_vec  = d;
    endtask

    task automatic step(input bit chk_on = 1'b1);
        model_step();
        cyc++;
        @(posedge clk);
        #1;
        if (chk_on) begin
            chk("vec", 32'(viol_vec), 32'(m_vec));
            chk("valid", 32'(viol_valid), 32'(|m_vec));
            chk("code", 32'(viol_code), 32'(lowest(m_vec)));
            chk("mask", 32'(viol_mask), 32'(m_mask));
            chk("busy", 32'(busy), 32'(m_pend));
            chk("cnt", 32'(cnt_value), 32'(m_cnt[cnt_sel]));
        end
    endtask

    task automatic idle_in();
        ce = 1; clr = 0; mode = 0; cmd = 0; inp_valid = 0;
        err = 0; oflow = 0; cout = 0; g = 0; l = 0; e = 0;
    endtask

    task automatic drain();
        inp_valid = 0;
        repeat (DUT_LAT + 1) step();
    endtask

    initial begin
        rst = 1; cin = 0; opa = 0; opb = 0; res = 0; cnt_sel = 0;
        idle_in();
        step(); step();
        chk("rst_vec", 32'(viol_vec), 0);
        chk("rst_valid", 32'(viol_valid), 0);
        chk("rst_mask", 32'(viol_mask), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt_value), 0);
        rst = 0;
        step();

        // Split operands, second arrives five cycles later.
        mode = 1; cmd = 0; opa = 8'h11; inp_valid = 2'b01;
        step();
        chk("t1_busy", 32'(busy), 1);
        inp_valid = 2'b00;
        repeat (4) step();
        chk("t1_busy5", 32'(busy), 1);
        opb = 8'h22; inp_valid = 2'b10;
        step();
        chk("t1_done", 32'(busy), 0);
        chk("t1_vec", 32'(viol_vec), 0);
        drain();

        // Operand timeout.
        cnt_sel = 2;
        inp_valid = 2'b01;
        step();
        inp_valid = 2'b00;
        repeat (WAIT_CYCLES - 1) step();
        chk("t2_busy", 32'(busy), 1);
        step();
        chk("t2_code", 32'(viol_code), 2);
        chk("t2_cnt", 32'(cnt_value), 1);
        chk("t2_busy_drop", 32'(busy), 0);

        // Command changes while waiting, then an illegal command.
        inp_valid = 2'b01;
        step();
        inp_valid = 2'b00;
        step(); step();
        cmd = 1;
        step();
        chk("t3_chg", 32'(viol_vec), 32'h08);
        mode = 0; cmd = 15; inp_valid = 2'b11;
        step();
        chk("t3_ill", 32'(viol_vec), 32'h01);
        drain();

        // Compare flags: wrong then right.
        mode = 1; cmd = 8; opa = 8'h20; opb = 8'h10; inp_valid = 2'b11;
        step();
        inp_valid = 2'b00;
        repeat (DUT_LAT - 1) step();
        g = 0; l = 1; e = 0;
        step();
        chk("t4_bad", 32'(viol_vec), 32'h40);
        inp_valid = 2'b11;
        step();
        inp_valid = 2'b00;
        repeat (DUT_LAT - 1) step();
        g = 1; l = 0; e = 0;
        step();
        chk("t4_ok", 32'(viol_vec), 0);
        idle_in();
        drain();

        // Rotate with out-of-range amount and no ERR, plus OFLOW.
        mode = 0; cmd = 12; opa = 8'h01; opb = 8'h30; inp_valid = 2'b11;
        step();
        inp_valid = 2'b00;
        repeat (DUT_LAT - 1) step();
        err = 0; oflow = 1;
        step();
        chk("t5_vec", 32'(viol_vec), 32'hA0);
        chk("t5_code", 32'(viol_code), 5);
        cnt_sel = 5; #1;
        chk("t5_cnt5", 32'(cnt_value), 1);
        cnt_sel = 7; #1;
        chk("t5_cnt7", 32'(cnt_value), 1);
        idle_in();
        drain();

        // Result moves while CE is low; then saturate that counter.
        cnt_sel = 4;
        ce = 0; res = 9'h005;
        step();
        res = 9'h006;
        step();
        chk("t6_hold", 32'(viol_vec), 32'h10);
        for (int i = 0; i < 65540; i++) begin
            res = res ^ 9'h001;
            step(1'b0);
        end
        chk("t6_sat", 32'(cnt_value), 32'hFFFF);
        chk("t6_sat_m", 32'(m_cnt[4]), 32'hFFFF);
        clr = 1; res = res ^ 9'h001;
        step();
        chk("t6_clr", 32'(cnt_value), 1);
        chk("t6_mask", 32'(viol_mask), 32'h10);
        clr = 0; ce = 1;
        step();

        // Reset while waiting drops everything.
        mode = 1; cmd = 0; inp_valid = 2'b01;
        step();
        chk("t6_wait", 32'(busy), 1);
        rst = 1;
        step();
        rst = 0; inp_valid = 2'b00;
        step();
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_vec", 32'(viol_vec), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 99) == 0);
            ce = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 30) begin
                mode = 1'($urandom);
                cmd = CMD_WIDTH'($urandom_range(0, 15));
            end
            inp_valid = 2'($urandom);
            opa = WIDTH'($urandom);
            opb = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
            if ($urandom_range(0, 99) < 30) res = 9'($urandom);
            err = 1'($urandom);
            oflow = ($urandom_range(0, 9) == 0);
            cout = ($urandom_range(0, 9) == 0);
            {g, l, e} = 3'(1 << $urandom_range(0, 2));
            cnt_sel = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
